cnn_layer_accel_fetch_driver: RTL and testbench

//  Host-side job/fetch engine for cnn_layer_accel_quad: issues job_start, answers each job_fetch_request by

---
 rtl/cnn_layer_accel_fetch_driver_if.sv | 53 +++++
 rtl/cnn_layer_accel_fetch_driver.sv | 148 ++++++++++++++
 tb/tb_cnn_layer_accel_fetch_driver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_accel_fetch_driver_if.sv
// Accelerator-side bus of the fetch driver: job handshakes, pixel memory read port
// and the packed pixel stream towards cnn_layer_accel_quad.
interface cnn_layer_accel_fetch_driver_if #(
    parameter int C_PIXEL_WIDTH  = 16,
    parameter int C_NUM_CHANNELS = 8,
    parameter int C_ADDR_WIDTH   = 16
);
    logic                                    job_start;
    logic                                    job_accept;
    logic                                    job_fetch_request;
    logic                                    job_fetch_ack;
    logic                                    job_fetch_complete;
    logic                                    job_complete;
    logic                                    job_complete_ack;
    logic                                    mem_rd_en;
    logic [C_ADDR_WIDTH-1:0]                 mem_rd_addr;
    logic [C_NUM_CHANNELS*C_PIXEL_WIDTH-1:0] mem_rd_data;
    logic                                    pixel_valid;
    logic                                    pixel_ready;
    logic [C_NUM_CHANNELS*C_PIXEL_WIDTH-1:0] pixel_data;

    modport master (
        output job_start,
        input  job_accept,
        input  job_fetch_request,
        output job_fetch_ack,
        output job_fetch_complete,
        input  job_complete,
        output job_complete_ack,
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output pixel_valid,
        input  pixel_ready,
        output pixel_data
    );

    modport slave (
        input  job_start,
        output job_accept,
        output job_fetch_request,
        input  job_fetch_ack,
        input  job_fetch_complete,
        output job_complete,
        input  job_complete_ack,
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  pixel_valid,
        output pixel_ready,
        input  pixel_data
    );
endinterface

// File: rtl/cnn_layer_accel_fetch_driver.sv
// Host-side job/fetch engine: starts a job, streams rows of packed pixels per fetch
// request from linear pixel memory (optional zero padding) and acknowledges completion.
module cnn_layer_accel_fetch_driver #(
    parameter int C_PIXEL_WIDTH    = 16,
    parameter int C_NUM_CHANNELS   = 8,
    parameter int C_ADDR_WIDTH     = 16,
    parameter int C_ROWS_PER_FETCH = 1
) (
    input  logic                    clk_if,
    input  logic                    rst,
    input  logic                    job_go,
    input  logic [15:0]             cfg_num_rows,
    input  logic [15:0]             cfg_num_cols,
    input  logic                    cfg_pad,
    input  logic [C_ADDR_WIDTH-1:0] cfg_base_addr,
    output logic                    busy,
    output logic                    job_done,
    output logic                    err,
    cnn_layer_accel_fetch_driver_if.master acc
);
    localparam int D = C_NUM_CHANNELS * C_PIXEL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_ACK, S_STREAM, S_FDONE, S_CMPL
    } state_t;

    state_t                  state, state_nx;
    logic [15:0]             rows_r, row_cnt;
    logic                    pad_r;
    logic [16:0]             width_r, pos;
    logic [C_ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]             iss_left, beats_left;
    logic                    v1, pad1;
    logic [D-1:0]            fifo_mem [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              cnt;
    logic                    err_r;

    logic [15:0] rows_left, fetch_rows;
    logic [31:0] fetch_beats;
    logic [2:0]  occ;
    logic        pop, issuing, iss_pad, last_beat;

    always_comb begin
        rows_left   = rows_r - row_cnt;
        fetch_rows  = (rows_left < 16'(C_ROWS_PER_FETCH)) ? rows_left : 16'(C_ROWS_PER_FETCH);
        fetch_beats = 32'(fetch_rows) * 32'(width_r);
        pop         = (cnt != 2'd0) && acc.pixel_ready;
        // Occupancy counts the read in flight and credits this cycle's pop, so a
        // 2-entry buffer sustains one beat per cycle without overflowing.
        occ         = {1'b0, cnt} + {2'b00, v1} - {2'b00, pop};
        issuing     = ((state == S_ACK) || (state == S_STREAM)) && (iss_left != 32'd0) && (occ < 3'd2);
        iss_pad     = pad_r && ((pos == 17'd0) || (pos == width_r - 17'd1));
        last_beat   = (state == S_STREAM) && pop && (beats_left == 32'd1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (job_go && cfg_num_rows != 16'd0 && cfg_num_cols != 16'd0) state_nx = S_START;
            S_START:  if (acc.job_accept) state_nx = S_WAIT;
            S_WAIT: begin
                if (acc.job_fetch_request)  state_nx = S_ACK;
                else if (acc.job_complete)  state_nx = S_CMPL;
            end
            S_ACK:    state_nx = S_STREAM;
            S_STREAM: if (beats_left == 32'd0 || last_beat) state_nx = S_FDONE;
            S_FDONE:  state_nx = S_WAIT;
            S_CMPL:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            state       <= S_IDLE;
            rows_r      <= '0;
            row_cnt     <= '0;
            pad_r       <= 1'b0;
            width_r     <= '0;
            pos         <= '0;
            rd_addr     <= '0;
            iss_left    <= '0;
            beats_left  <= '0;
            v1          <= 1'b0;
            pad1        <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            cnt         <= '0;
            err_r       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && job_go) begin
                if (cfg_num_rows != 16'd0 && cfg_num_cols != 16'd0) begin
                    rows_r  <= cfg_num_rows;
                    pad_r   <= cfg_pad;
                    width_r <= {1'b0, cfg_num_cols} + (cfg_pad ? 17'd2 : 17'd0);
                    rd_addr <= cfg_base_addr;
                    row_cnt <= '0;
                end else begin
                    err_r <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                if (acc.job_fetch_request) begin
                    iss_left   <= fetch_beats;
                    beats_left <= fetch_beats;
                    pos        <= '0;
                    row_cnt    <= row_cnt + fetch_rows;
                    if (rows_left == 16'd0) err_r <= 1'b1;
                end else if (acc.job_complete && rows_left != 16'd0) begin
                    err_r <= 1'b1;
                end
            end
            if (issuing) begin
                iss_left <= iss_left - 32'd1;
                pos      <= (pos == width_r - 17'd1) ? 17'd0 : pos + 17'd1;
                if (!iss_pad) rd_addr <= rd_addr + 1'b1;
            end
            // Pad beats ride the same one-cycle stage as reads so order is kept.
            v1   <= issuing;
            pad1 <= iss_pad;
            if (v1) begin
                fifo_mem[wr_ptr] <= pad1 ? '0 : acc.mem_rd_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (beats_left != 32'd0) beats_left <= beats_left - 32'd1;
            end
            cnt <= cnt + 2'(v1) - 2'(pop);
        end
    end

    assign busy                   = (state != S_IDLE);
    assign job_done               = (state == S_CMPL);
    assign err                    = err_r;
    assign acc.job_start          = (state == S_START);
    assign acc.job_fetch_ack      = (state == S_ACK);
    assign acc.job_fetch_complete = (state == S_FDONE);
    assign acc.job_complete_ack   = (state == S_CMPL);
    assign acc.mem_rd_en          = issuing && !iss_pad;
    assign acc.mem_rd_addr        = rd_addr;
    assign acc.pixel_valid        = (cnt != 2'd0);
    assign acc.pixel_data         = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_cnn_layer_accel_fetch_driver.sv
// Directed bench for cnn_layer_accel_fetch_driver: two instances (1 and 2 rows per fetch),
// behavioural pixel memory and accel-side handshake driven from one initial block.
module tb_cnn_layer_accel_fetch_driver;
    localparam int W = 16;
    localparam int N = 8;
    localparam int A = 16;
    localparam int D = W * N;

    logic clk_if = 1'b0;
    always #5 clk_if = ~clk_if;

    logic          rst, go, pad, sel;
    logic [15:0]   rows, cols;
    logic [A-1:0]  base;
    logic          acc_accept, acc_freq, acc_comp, acc_ready;
    logic          busy1, done1, err1, busy2, done2, err2;
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [D-1:0]  expq [$];

    cnn_layer_accel_fetch_driver_if #(.C_PIXEL_WIDTH(W), .C_NUM_CHANNELS(N), .C_ADDR_WIDTH(A)) if1 ();
    cnn_layer_accel_fetch_driver_if #(.C_PIXEL_WIDTH(W), .C_NUM_CHANNELS(N), .C_ADDR_WIDTH(A)) if2 ();

    function automatic logic [D-1:0] pix(input logic [A-1:0] addr);
        logic [D-1:0] d;
        for (int c = 0; c < N; c++) d[c*W +: W] = addr ^ {4'(8 + c), 12'h000};
        return d;
    endfunction

    assign if1.job_accept        = acc_accept & ~sel;
    assign if1.job_fetch_request = acc_freq & ~sel;
    assign if1.job_complete      = acc_comp & ~sel;
    assign if1.pixel_ready       = acc_ready & ~sel;
    assign if2.job_accept        = acc_accept & sel;
    assign if2.job_fetch_request = acc_freq & sel;
    assign if2.job_complete      = acc_comp & sel;
    assign if2.pixel_ready       = acc_ready & sel;

    always @(posedge clk_if) if (if1.mem_rd_en) if1.mem_rd_data <= pix(if1.mem_rd_addr);
    always @(posedge clk_if) if (if2.mem_rd_en) if2.mem_rd_data <= pix(if2.mem_rd_addr);

    cnn_layer_accel_fetch_driver #(.C_PIXEL_WIDTH(W), .C_NUM_CHANNELS(N), .C_ADDR_WIDTH(A),
                                   .C_ROWS_PER_FETCH(1)) dut1 (
        .clk_if(clk_if), .rst(rst), .job_go(go & ~sel), .cfg_num_rows(rows), .cfg_num_cols(cols),
        .cfg_pad(pad), .cfg_base_addr(base), .busy(busy1), .job_done(done1), .err(err1), .acc(if1.master));

    cnn_layer_accel_fetch_driver #(.C_PIXEL_WIDTH(W), .C_NUM_CHANNELS(N), .C_ADDR_WIDTH(A),
                                   .C_ROWS_PER_FETCH(2)) dut2 (
        .clk_if(clk_if), .rst(rst), .job_go(go & sel), .cfg_num_rows(rows), .cfg_num_cols(cols),
        .cfg_pad(pad), .cfg_base_addr(base), .busy(busy2), .job_done(done2), .err(err2), .acc(if2.master));

    logic         o_busy, o_done, o_err, o_start, o_fack, o_fcmp, o_cack, o_rd_en, o_valid;
    logic [A-1:0] o_rd_addr;
    logic [D-1:0] o_data;
    assign o_busy    = sel ? busy2 : busy1;
    assign o_done    = sel ? done2 : done1;
    assign o_err     = sel ? err2  : err1;
    assign o_start   = sel ? if2.job_start          : if1.job_start;
    assign o_fack    = sel ? if2.job_fetch_ack      : if1.job_fetch_ack;
    assign o_fcmp    = sel ? if2.job_fetch_complete : if1.job_fetch_complete;
    assign o_cack    = sel ? if2.job_complete_ack   : if1.job_complete_ack;
    assign o_rd_en   = sel ? if2.mem_rd_en          : if1.mem_rd_en;
    assign o_rd_addr = sel ? if2.mem_rd_addr        : if1.mem_rd_addr;
    assign o_valid   = sel ? if2.pixel_valid        : if1.pixel_valid;
    assign o_data    = sel ? if2.pixel_data         : if1.pixel_data;

    task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_row(input logic [A-1:0] row_base, input int ncols, input logic p);
        if (p) expq.push_back('0);
        for (int c = 0; c < ncols; c++) expq.push_back(pix(row_base + A'(c)));
        if (p) expq.push_back('0);
    endtask

    task automatic start_job(input int r, input int c, input logic p, input logic [A-1:0] b);
        rows = 16'(r); cols = 16'(c); pad = p; base = b; go = 1'b1;
        @(negedge clk_if);
        go = 1'b0;
        for (int t = 0; t < 20 && !o_start; t++) @(negedge clk_if);
        chk("job_start", o_start, 1);
        chk("busy_start", o_busy, 1);
        acc_accept = 1'b1;
        @(negedge clk_if);
        acc_accept = 1'b0;
        chk("job_start_drop", o_start, 0);
    endtask

    task automatic do_fetch(input bit rnd, input int exp_beats, input int exp_rd, output int lat);
        int           rd, nbeats;
        bit           hold;
        logic [D-1:0] held;
        rd = 0; nbeats = 0; hold = 0; held = '0; lat = -1;
        acc_freq = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_if);
            if (o_fack) break;
        end
        chk("fetch_ack", o_fack, 1);
        acc_freq = 1'b0;
        if (o_rd_en) rd++;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk_if);
            acc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (o_fcmp) break;
            if (o_rd_en) rd++;
            if (hold) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data, held);
            end
            if (o_valid && lat < 0) lat = cyc;
            if (o_valid && acc_ready) begin
                nbeats++;
                if (expq.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat", o_data, expq.pop_front());
            end
            hold = o_valid && !acc_ready;
            held = o_data;
        end
        chk("fetch_complete", o_fcmp, 1);
        chk("fdone_valid", o_valid, 0);
        chk("beat_count", nbeats, exp_beats);
        chk("rd_count", rd, exp_rd);
        chk("leftover", expq.size(), 0);
        acc_ready = 1'b1;
    endtask

    task automatic finish_job();
        acc_comp = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_if);
            if (o_cack) break;
        end
        chk("complete_ack", o_cack, 1);
        chk("job_done", o_done, 1);
        acc_comp = 1'b0;
        @(negedge clk_if);
        chk("job_done_pulse", o_done, 0);
        chk("busy_end", o_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; go = 1'b0; pad = 1'b0; sel = 1'b0; rows = '0; cols = '0; base = '0;
        acc_accept = 1'b0; acc_freq = 1'b0; acc_comp = 1'b0; acc_ready = 1'b1;
        repeat (3) @(negedge clk_if);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_start, 0);
        chk("rst_err", o_err, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_data", o_data, 0);
        rst = 1'b0;
        @(negedge clk_if);

        // T1: 4 rows x 10 cols, address range wraps past 0xFFFF
        start_job(4, 10, 1'b0, 16'hFFFB);
        for (int r = 0; r < 4; r++) begin
            push_row(16'hFFFB + 16'(r * 10), 10, 1'b0);
            do_fetch(1'b0, 10, 10, lat);
            if (r == 0) chk("first_latency", lat, 2);
        end
        chk("t1_err", o_err, 0);
        finish_job();

        // T2: random ready
        start_job(4, 10, 1'b0, 16'h1000);
        for (int r = 0; r < 4; r++) begin
            push_row(16'h1000 + 16'(r * 10), 10, 1'b0);
            do_fetch(1'b1, 10, 10, lat);
        end
        finish_job();

        // T3: padding
        start_job(2, 3, 1'b1, 16'h2000);
        for (int r = 0; r < 2; r++) begin
            push_row(16'h2000 + 16'(r * 3), 3, 1'b1);
            do_fetch(1'b0, 5, 3, lat);
        end
        chk("t3_err", o_err, 0);
        finish_job();

        // T4: two rows per fetch, extra request after the last row
        sel = 1'b1;
        @(negedge clk_if);
        start_job(5, 4, 1'b0, 16'h3000);
        push_row(16'h3000, 4, 1'b0); push_row(16'h3004, 4, 1'b0);
        do_fetch(1'b0, 8, 8, lat);
        push_row(16'h3008, 4, 1'b0); push_row(16'h300C, 4, 1'b0);
        do_fetch(1'b1, 8, 8, lat);
        push_row(16'h3010, 4, 1'b0);
        do_fetch(1'b0, 4, 4, lat);
        chk("t4_err_before", o_err, 0);
        do_fetch(1'b0, 0, 0, lat);
        chk("t4_err_after", o_err, 1);
        finish_job();

        // T5: zero-column job rejected; job_go while busy ignored
        sel = 1'b0;
        @(negedge clk_if);
        chk("t5_err_before", o_err, 0);
        rows = 16'd2; cols = 16'd0; go = 1'b1;
        @(negedge clk_if);
        go = 1'b0;
        repeat (3) @(negedge clk_if);
        chk("t5_no_start", o_start, 0);
        chk("t5_not_busy", o_busy, 0);
        chk("t5_err", o_err, 1);
        start_job(2, 2, 1'b0, 16'h4000);
        rows = 16'd1; cols = 16'd5; pad = 1'b1; base = 16'h5000; go = 1'b1;
        @(negedge clk_if);
        go = 1'b0;
        chk("t5_busy_go_start", o_start, 0);
        push_row(16'h4000, 2, 1'b0);
        do_fetch(1'b0, 2, 2, lat);
        push_row(16'h4002, 2, 1'b0);
        do_fetch(1'b0, 2, 2, lat);
        finish_job();

        // T6: reset mid-stream, then restart from row 0
        start_job(3, 8, 1'b0, 16'h6000);
        acc_freq = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_if);
            if (o_fack) break;
        end
        acc_freq = 1'b0;
        repeat (4) @(negedge clk_if);
        chk("t6_midstream_valid", o_valid, 1);
        rst = 1'b1;
        @(negedge clk_if);
        chk("t6_busy", o_busy, 0);
        chk("t6_valid", o_valid, 0);
        chk("t6_data", o_data, 0);
        chk("t6_rd_en", o_rd_en, 0);
        chk("t6_rd_addr", o_rd_addr, 0);
        chk("t6_fack", o_fack, 0);
        chk("t6_fcmp", o_fcmp, 0);
        chk("t6_cack", o_cack, 0);
        chk("t6_done", o_done, 0);
        chk("t6_err", o_err, 0);
        rst = 1'b0;
        @(negedge clk_if);
        start_job(3, 8, 1'b0, 16'h6000);
        push_row(16'h6000, 8, 1'b0);
        do_fetch(1'b0, 8, 8, lat);
        chk("t6_restart_latency", lat, 2);
        chk("t6_err_mid", o_err, 0);
        finish_job();
        chk("t6_early_complete_err", o_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
